// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: shares the single Sysbus master port between instruction
// fetch (port 0) and data memory (port 1). One transaction is outstanding at
// a time and grants are round-robin. Request, write-data and response beats
// are routed only to the port that owns the current transaction.
// Optional build macro: ARB_STATS_EN adds grant/wait statistics counters.
module sysbus_arbiter #(
   parameter int   DATA_W    = 64,
   parameter int   TAG_W     = 13,
   parameter int   BEATS     = 8,
   parameter logic WRITE_VAL = 1'b0
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              m0_reqcyc,
   input  logic [DATA_W-1:0] m0_req,
   input  logic [TAG_W-1:0]  m0_reqtag,
   output logic              m0_reqack,
   output logic              m0_respcyc,
   output logic [DATA_W-1:0] m0_resp,
   output logic [TAG_W-1:0]  m0_resptag,
   input  logic              m0_respack,

   input  logic              m1_reqcyc,
   input  logic [DATA_W-1:0] m1_req,
   input  logic [TAG_W-1:0]  m1_reqtag,
   output logic              m1_reqack,
   output logic              m1_respcyc,
   output logic [DATA_W-1:0] m1_resp,
   output logic [TAG_W-1:0]  m1_resptag,
   input  logic              m1_respack,

   output logic              bus_reqcyc,
   output logic [DATA_W-1:0] bus_req,
   output logic [TAG_W-1:0]  bus_reqtag,
   input  logic              bus_reqack,
   input  logic              bus_respcyc,
   input  logic [DATA_W-1:0] bus_resp,
   input  logic [TAG_W-1:0]  bus_resptag,
   output logic              bus_respack
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]       stat_grant0,
   output logic [31:0]       stat_grant1,
   output logic [31:0]       stat_wait
`endif
);

   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, ADDR, WDATA, RESP} state_t;

   state_t           state;
   logic             owner;
   logic             last_grant;
   logic             is_write;
   logic [CNT_W-1:0] beat_cnt;

   logic own_reqcyc;
   logic own_respack;
   logic grant_any;
   logic grant_port;
   logic grant_write;
   logic req_phase;
   logic resp_phase;

   // Owner-side views of the request/response handshakes and the grant pick.
   always_comb begin
      own_reqcyc  = owner ? m1_reqcyc  : m0_reqcyc;
      own_respack = owner ? m1_respack : m0_respack;
      grant_any   = m0_reqcyc | m1_reqcyc;
      // On contention the port that did not win last time goes next.
      if (m0_reqcyc && m1_reqcyc)
         grant_port = ~last_grant;
      else
         grant_port = m1_reqcyc;
      grant_write = (grant_port ? m1_reqtag[TAG_W-1] : m0_reqtag[TAG_W-1]) == WRITE_VAL;
      req_phase   = (state == ADDR) || (state == WDATA);
      resp_phase  = (state == RESP);
   end

   // Route request and response paths to/from the owner only; everything is
   // zero while idle, so reset forces all outputs low immediately.
   always_comb begin
      bus_reqcyc  = req_phase & own_reqcyc;
      bus_req     = req_phase ? (owner ? m1_req : m0_req) : '0;
      bus_reqtag  = req_phase ? (owner ? m1_reqtag : m0_reqtag) : '0;
      m0_reqack   = req_phase & ~owner & bus_reqack;
      m1_reqack   = req_phase &  owner & bus_reqack;

      m0_respcyc  = resp_phase & ~owner & bus_respcyc;
      m1_respcyc  = resp_phase &  owner & bus_respcyc;
      m0_resp     = (resp_phase & ~owner) ? bus_resp    : '0;
      m1_resp     = (resp_phase &  owner) ? bus_resp    : '0;
      m0_resptag  = (resp_phase & ~owner) ? bus_resptag : '0;
      m1_resptag  = (resp_phase &  owner) ? bus_resptag : '0;
      bus_respack = resp_phase & own_respack;
   end

   // Transaction FSM: grant, address beat, optional write data, read response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         is_write   <= 1'b0;
         beat_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  owner      <= grant_port;
                  last_grant <= grant_port;
                  is_write   <= grant_write;
                  beat_cnt   <= '0;
                  state      <= ADDR;
               end
            end
            ADDR: begin
               // A requester withdrawing before the address is taken abandons
               // the transaction without using the bus.
               if (!own_reqcyc) begin
                  state <= IDLE;
               end else if (bus_reqack) begin
                  beat_cnt <= '0;
                  state    <= is_write ? WDATA : RESP;
               end
            end
            WDATA: begin
               if (own_reqcyc && bus_reqack) begin
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt <= '0;
                     state    <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            RESP: begin
               if (bus_respcyc && own_respack) begin
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt <= '0;
                     state    <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Response beats outside the response phase have nowhere to go and are dropped.
   a_resp_only_in_resp: assert property (@(posedge clk) disable iff (reset)
      bus_respcyc |-> (state == RESP));

`ifdef ARB_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   // Saturating grant counts per port and cycles a non-owner spends waiting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_grant0 <= '0;
         stat_grant1 <= '0;
         stat_wait   <= '0;
      end else begin
         if (state == IDLE && grant_any && !grant_port)
            stat_grant0 <= sat_inc(stat_grant0);
         if (state == IDLE && grant_any && grant_port)
            stat_grant1 <= sat_inc(stat_grant1);
         if (state != IDLE && (owner ? m0_reqcyc : m1_reqcyc))
            stat_wait <= sat_inc(stat_wait);
      end
   end
`endif

endmodule
